// File: rtl/wb_stage_pkg.sv
// Shared RV32I core definitions used by the write-back stage and the load/store path.
package wb_stage_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_PC4  = 2'b10,
      WB_RSVD = 2'b11
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Unknown funct3 encodings are handled as word accesses, so they share the word alignment rule.
   function automatic logic access_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3)
         F3_LB, F3_LBU: access_misaligned = 1'b0;
         F3_LH, F3_LHU: access_misaligned = off[0];
         default:       access_misaligned = (off != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load-data formatter: picks the addressed lane and extends it by funct3.
module load_align
   import wb_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      off_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o,
   output logic            misaligned_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Misaligned halfwords fall back to the lane chosen by off[1]; the low bit is ignored.
   assign byte_lane    = rdata_i[{off_i, 3'b000} +: 8];
   assign half_lane    = rdata_i[{off_i[1], 4'b0000} +: 16];
   assign misaligned_o = access_misaligned(funct3_i, off_i);

   always_comb begin
      data_o = rdata_i;
      case (funct3_i)
         F3_LB:   data_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
         F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_lane};
         F3_LH:   data_o = {{(XLEN-16){half_lane[15]}}, half_lane};
         F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_lane};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with write-back source selection, load formatting,
// a forwarding tap and the retired-instruction counter.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   input  logic             mem_valid,
   input  logic [31:0]      mem_inst,
   input  logic [XLEN-1:0]  mem_alu_result,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic [XLEN-1:0]  mem_pc,
   input  logic             mem_reg_write,
   input  logic [1:0]       mem_wb_sel,
   output logic             reg_write,
   output logic [31:0]      wb_inst,
   output logic [XLEN-1:0]  write_data,
   output logic             fwd_valid,
   output logic             wb_misaligned,
   output logic [CNT_W-1:0] instret
);

   logic             cap;
   logic             valid_q;
   logic             wbreg_q;
   logic             wbreg_d;
   logic [31:0]      inst_q;
   logic [31:0]      inst_d;
   logic [XLEN-1:0]  wdata_q;
   logic [XLEN-1:0]  wdata_d;
   logic             mis_q;
   logic             mis_d;
   logic [CNT_W-1:0] instret_q;
   logic [CNT_W-1:0] instret_d;
   logic [XLEN-1:0]  load_data;
   logic             load_mis;
   logic             is_load;

   // Flush wins over everything; a stalled instruction is re-presented and taken later.
   assign cap     = mem_valid & ~stall & ~flush;
   assign is_load = (wb_sel_e'(mem_wb_sel) == WB_LOAD);

   load_align #(.XLEN(XLEN)) u_load_align (
      .rdata_i      (mem_rdata),
      .off_i        (mem_alu_result[1:0]),
      .funct3_i     (mem_inst[14:12]),
      .data_o       (load_data),
      .misaligned_o (load_mis)
   );

   always_comb begin
      wdata_d = mem_alu_result;
      case (wb_sel_e'(mem_wb_sel))
         WB_LOAD: wdata_d = load_data;
         WB_PC4:  wdata_d = mem_pc + XLEN'(4);
         default: wdata_d = mem_alu_result;
      endcase
   end

   assign wbreg_d   = cap & mem_reg_write;
   assign inst_d    = cap ? mem_inst : NOP_INST;
   assign mis_d     = cap & is_load & load_mis;
   // Counted as it enters WB so the count lines up with the instruction it reports.
   assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, cap};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         wbreg_q   <= 1'b0;
         inst_q    <= NOP_INST;
         wdata_q   <= '0;
         mis_q     <= 1'b0;
         instret_q <= '0;
      end else begin
         valid_q   <= cap;
         wbreg_q   <= wbreg_d;
         inst_q    <= inst_d;
         mis_q     <= mis_d;
         instret_q <= instret_d;
         if (cap) begin
            wdata_q <= wdata_d;
         end
      end
   end

   assign reg_write     = valid_q & wbreg_q & (inst_q[11:7] != 5'd0);
   assign fwd_valid     = reg_write;
   assign wb_inst       = inst_q;
   assign write_data    = wdata_q;
   assign wb_misaligned = mis_q;
   assign instret       = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed and randomized checks of wb_stage against a behavioural write-back model.
module tb_wb_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        mem_valid;
   logic [31:0] mem_inst;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_rdata;
   logic [31:0] mem_pc;
   logic        mem_reg_write;
   logic [1:0]  mem_wb_sel;
   logic        reg_write;
   logic [31:0] wb_inst;
   logic [31:0] write_data;
   logic        fwd_valid;
   logic        wb_misaligned;
   logic [63:0] instret;

   int checks;
   int failures;

   logic        expRegWrite;
   logic [31:0] expInst;
   logic [31:0] expData;
   logic        expMis;
   logic [63:0] expCnt;
   int          pulses;

   wb_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .flush          (flush),
      .mem_valid      (mem_valid),
      .mem_inst       (mem_inst),
      .mem_alu_result (mem_alu_result),
      .mem_rdata      (mem_rdata),
      .mem_pc         (mem_pc),
      .mem_reg_write  (mem_reg_write),
      .mem_wb_sel     (mem_wb_sel),
      .reg_write      (reg_write),
      .wb_inst        (wb_inst),
      .write_data     (write_data),
      .fwd_valid      (fwd_valid),
      .wb_misaligned  (wb_misaligned),
      .instret        (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Load result from the RISC-V load rules using plain shifts and two's-complement arithmetic.
   function automatic logic [31:0] loadValue(input logic [31:0] rdata, input logic [2:0] f3,
                                             input logic [1:0] off);
      int unsigned b;
      int unsigned h;
      b = (rdata >> (8 * off)) & 32'hFF;
      h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? b - 256 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h - 65536 : h;
         3'd5:    return h;
         default: return rdata;
      endcase
   endfunction

   function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] off);
      if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
      if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) != 0;
      return off != 0;
   endfunction

   function automatic logic [31:0] mkInst(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
      return {17'd0, f3, rd, opc};
   endfunction

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, ".reg_write"}, 64'(reg_write), 64'(expRegWrite));
      checkVal({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(expRegWrite));
      checkVal({tag, ".wb_inst"}, 64'(wb_inst), 64'(expInst));
      checkVal({tag, ".write_data"}, 64'(write_data), 64'(expData));
      checkVal({tag, ".wb_misaligned"}, 64'(wb_misaligned), 64'(expMis));
      checkVal({tag, ".instret"}, instret, expCnt);
   endtask

   // Drive one MEM-stage cycle, update the model and advance past the capturing edge.
   task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] alu,
                                input logic [31:0] rdata, input logic [31:0] pc,
                                input logic rw, input logic [1:0] sel,
                                input logic st, input logic fl);
      logic taken;
      mem_valid      = v;
      mem_inst       = inst;
      mem_alu_result = alu;
      mem_rdata      = rdata;
      mem_pc         = pc;
      mem_reg_write  = rw;
      mem_wb_sel     = sel;
      stall          = st;
      flush          = fl;
      taken = v && !st && !fl;
      if (taken) begin
         expInst     = inst;
         expRegWrite = rw && (inst[11:7] != 0);
         expCnt      = expCnt + 1;
         if (sel == 2'd1) begin
            expData = loadValue(rdata, inst[14:12], alu[1:0]);
            expMis  = isMisaligned(inst[14:12], alu[1:0]);
         end else begin
            expData = (sel == 2'd2) ? pc + 32'd4 : alu;
            expMis  = 1'b0;
         end
      end else begin
         expInst     = 32'h0000_0013;
         expRegWrite = 1'b0;
         expMis      = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      expRegWrite = 1'b0;
      expInst     = 32'h0000_0013;
      expData     = 32'd0;
      expMis      = 1'b0;
      expCnt      = 64'd0;
   endtask

   initial begin
      logic [31:0] rd32;
      logic [31:0] rinst;
      checks   = 0;
      failures = 0;
      pulses   = 0;
      rst_n = 1'b0;
      mem_valid = 1'b0; mem_inst = 32'h13; mem_alu_result = 0; mem_rdata = 0;
      mem_pc = 0; mem_reg_write = 1'b0; mem_wb_sel = 2'd0; stall = 1'b0; flush = 1'b0;
      modelReset();
      #12;
      checkOutput("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // ADDI x5
      applyStimulus(1, {12'h0, 5'd0, 3'd0, 5'd5, 7'h13}, 32'h1234, 0, 32'h100, 1, 2'd0, 0, 0);
      checkOutput("addi");
      checkVal("addi.rd", 64'(wb_inst[11:7]), 64'd5);
      checkVal("addi.data_const", 64'(write_data), 64'h1234);
      checkVal("addi.instret_const", instret, 64'd1);

      rd32 = 32'h80FF7F01;
      applyStimulus(1, mkInst(3'd0, 5'd3, 7'h03), 32'h2002, rd32, 0, 1, 2'd1, 0, 0);
      checkOutput("lb");
      checkVal("lb.const", 64'(write_data), 64'hFFFFFFFF);
      applyStimulus(1, mkInst(3'd4, 5'd3, 7'h03), 32'h2001, rd32, 0, 1, 2'd1, 0, 0);
      checkOutput("lbu");
      checkVal("lbu.const", 64'(write_data), 64'h7F);
      applyStimulus(1, mkInst(3'd1, 5'd3, 7'h03), 32'h2002, rd32, 0, 1, 2'd1, 0, 0);
      checkOutput("lh");
      checkVal("lh.const", 64'(write_data), 64'hFFFF80FF);
      applyStimulus(1, mkInst(3'd5, 5'd3, 7'h03), 32'h2000, rd32, 0, 1, 2'd1, 0, 0);
      checkOutput("lhu");
      checkVal("lhu.const", 64'(write_data), 64'h7F01);
      applyStimulus(1, mkInst(3'd2, 5'd3, 7'h03), 32'h2000, rd32, 0, 1, 2'd1, 0, 0);
      checkOutput("lw");
      checkVal("lw.const", 64'(write_data), 64'h80FF7F01);

      applyStimulus(1, mkInst(3'd1, 5'd3, 7'h03), 32'h2001, rd32, 0, 1, 2'd1, 0, 0);
      checkOutput("lh_mis");
      checkVal("lh_mis.flag", 64'(wb_misaligned), 64'd1);
      checkVal("lh_mis.data", 64'(write_data), 64'h7F01);
      applyStimulus(0, 32'h13, 0, 0, 0, 0, 2'd0, 0, 0);
      checkOutput("mis_clears");

      applyStimulus(1, mkInst(3'd0, 5'd1, 7'h6F), 32'h0, 0, 32'hFFFFFFFC, 1, 2'd2, 0, 0);
      checkOutput("jal_wrap");
      checkVal("jal_wrap.const", 64'(write_data), 64'd0);

      applyStimulus(1, {12'h7, 5'd0, 3'd0, 5'd0, 7'h13}, 32'h55, 0, 0, 1, 2'd0, 0, 0);
      checkOutput("x0");
      applyStimulus(1, mkInst(3'd0, 5'd7, 7'h13), 32'h66, 0, 0, 1, 2'd0, 0, 1);
      checkOutput("flush");
      applyStimulus(1, mkInst(3'd0, 5'd7, 7'h13), 32'h77, 0, 0, 1, 2'd0, 1, 1);
      checkOutput("flush_stall");

      applyStimulus(1, mkInst(3'd0, 5'd9, 7'h13), 32'h99, 0, 0, 1, 2'd0, 1, 0);
      checkOutput("stall1");
      pulses += int'(reg_write);
      applyStimulus(1, mkInst(3'd0, 5'd9, 7'h13), 32'h99, 0, 0, 1, 2'd0, 1, 0);
      checkOutput("stall2");
      pulses += int'(reg_write);
      applyStimulus(1, mkInst(3'd0, 5'd9, 7'h13), 32'h99, 0, 0, 1, 2'd0, 0, 0);
      checkOutput("stall_release");
      pulses += int'(reg_write);
      applyStimulus(0, 32'h13, 0, 0, 0, 0, 2'd0, 0, 0);
      checkOutput("stall_after");
      pulses += int'(reg_write);
      checkVal("stall.pulses", 64'(pulses), 64'd1);

      for (int i = 0; i < 60; i++) begin
         rinst = $urandom;
         applyStimulus(1'($urandom_range(0, 3) != 0), rinst, $urandom, $urandom, $urandom,
                       1'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 5) == 0));
         checkOutput("random");
      end

      // Asynchronous reset mid-operation, asserted away from any clock edge.
      applyStimulus(1, mkInst(3'd0, 5'd4, 7'h13), 32'hABCD, 0, 0, 1, 2'd0, 0, 0);
      checkOutput("pre_reset");
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 32'h13, 0, 0, 0, 0, 2'd0, 0, 0);
      checkOutput("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus write-back formatting for the RV32I core.
- Captures the instruction leaving the memory stage and formats load data (byte/half/word, signed/unsigned).
- Selects the write-back source and drives the register file's write port (write enable, write instruction, write data).
- Also exposes a forwarding tap and a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 64, retired-instruction counter width.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard-unit stall; the MEM instruction is not consumed this cycle.
- flush  in  1  squash the MEM instruction (trap/redirect).
- mem_valid  in  1  MEM-stage instruction present.
- mem_inst  in  32  MEM-stage instruction word.
- mem_alu_result  in  XLEN  ALU result / effective address.
- mem_rdata  in  XLEN  raw aligned word from data memory.
- mem_pc  in  XLEN  PC of the MEM instruction.
- mem_reg_write  in  1  instruction writes rd.
- mem_wb_sel  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- reg_write  out  1  register-file write enable.
- wb_inst  out  32  instruction in WB; rd = wb_inst[11:7].
- write_data  out  XLEN  register-file write data.
- fwd_valid  out  1  forwarding tap valid (equals reg_write).
- wb_misaligned  out  1  one-cycle flag: the WB load was misaligned.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0) clears all outputs and internal state:
  - valid_q, reg_write, fwd_valid, wb_misaligned = 0.
  - wb_inst = 32'h0000_0013 (NOP).
  - write_data = 0, instret = 0.
- Capture condition: cap = mem_valid & ~stall & ~flush.
  - If cap: register all fields on the clock edge.
  - Else: load a bubble (valid_q = 0, wb_inst = NOP, wb_misaligned = 0); write_data holds.
  - flush and stall together: bubble. Flush also has priority in general.
- Latency: exactly 1 cycle from MEM inputs to WB outputs.
  - No combinational path from any input to any output.
- Stall contract: while stall=1 the upstream stage re-presents the same instruction. It is consumed only on the first cycle with stall=0, so each instruction is written and counted exactly once.
- reg_write = valid_q & wbreg_q & (rd != 0). x0 is never written and never forwarded.
- write_data is computed in the capture cycle and registered:
  - sel 00/11: mem_alu_result.
  - sel 10: mem_pc + 4, modulo 2^32.
  - sel 01: load formatting using funct3 = mem_inst[14:12] and off = mem_alu_result[1:0]:
    - LB 000: byte at lane off, sign-extended.
    - LBU 100: same byte, zero-extended.
    - LH 001: halfword at lane off[1], sign-extended.
    - LHU 101: same halfword, zero-extended.
    - LW 010: full word.
    - Other funct3 values: full word, treated as LW.
- Misalignment (load only):
  - Halfword with off[0]=1, or word with off != 0, sets wb_misaligned=1 in the WB cycle.
  - Data is still formatted as above, ignoring the offending low bits; the write still occurs. Trap handling is owned elsewhere.
- instret increments by 1 in every cycle where valid_q=1, whether or not rd is written. It wraps at 2^CNT_W to 0.

Decomposition:
- Shared core package holds:
  - WB select encodings (WB_ALU, WB_LOAD, WB_PC4).
  - funct3 load encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - The NOP constant 32'h0000_0013.
- One sub-module: load_align, purely combinational (rdata, off, funct3 -> formatted data, misaligned). It is reused later by the store/LSU path.

Test Plan:
- Reset mid-operation: rst_n low while valid_q=1 -> outputs go to reset values immediately (asynchronous), without waiting for clk; instret=0.
- ALU write: inst=ADDI x5 (rd=5), sel=00, alu=0x1234, mem_valid=1 -> next cycle reg_write=1, wb_inst[11:7]=5, write_data=0x00001234, instret=1.
- Load formatting: rdata=0x80FF7F01, rd=3:
  - LB off=2 -> 0xFFFFFFFF.
  - LBU off=1 -> 0x0000007F.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - LW off=0 -> 0x80FF7F01.
- Misaligned and JAL: LH off=1 -> wb_misaligned=1 for one cycle, write_data=0x00007F01. JAL rd=1, pc=0xFFFFFFFC, sel=10 -> write_data=0x00000000 (wrap).
- x0 and bubbles: rd=0 with mem_reg_write=1 -> reg_write=0, instret still +1. flush=1 (with or without stall) -> next cycle reg_write=0, wb_inst=0x00000013, instret unchanged.
- Stall: mem_valid=1 held for 3 cycles with stall=1,1,0 -> exactly one reg_write pulse, in the cycle after stall drops; instret +1 total.
